// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the parametrised 4-stage core (IF, ID, EX, WB):
//   - opcode_e     : 2-bit opcode encoding in the top bits of each instruction
//   - instr_w()    : instruction width from the register-address and
//                    immediate field widths
//   - op_lsb()     : bit position of the opcode field
//   - rd_lsb()     : bit position of the destination-register field
//   - op_writes()  : whether an opcode writes the register file
// ---------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        OP_MOVI = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_JMP  = 2'b11
    } opcode_e;

    function automatic int instr_w(input int reg_aw, input int imm_w);
        return 2 + reg_aw + imm_w;
    endfunction

    function automatic int op_lsb(input int reg_aw, input int imm_w);
        return reg_aw + imm_w;
    endfunction

    function automatic int rd_lsb(input int imm_w);
        return imm_w;
    endfunction

    function automatic logic op_writes(input opcode_e op);
        return op != OP_JMP;
    endfunction

endpackage

// File: rtl/pipelined_core_param_if.sv
// ---------------------------------------------------------------------------
// pipelined_core_param_if
// Bundles the core's instruction-memory port and its retire/observe port.
//   imem_addr  : fetch PC driven by the core
//   imem_rdata : instruction at imem_addr, returned in the same cycle
//   imem_valid : imem_rdata is valid this cycle (0 stalls the fetch)
//   wb_valid   : an instruction retires this cycle
//   wb_rd      : destination register of the retiring instruction
//   wb_data    : result of the retiring instruction
// Modports: master = core side, slave = memory / observer side.
// ---------------------------------------------------------------------------
interface pipelined_core_param_if
    import core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 3,
    parameter int PC_W   = 8
);
    localparam int INSTR_W = instr_w(REG_AW, IMM_W);

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic               wb_valid;
    logic [REG_AW-1:0]  wb_rd;
    logic [DATA_W-1:0]  wb_data;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  imem_valid,
        output wb_valid,
        output wb_rd,
        output wb_data
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output imem_valid,
        input  wb_valid,
        input  wb_rd,
        input  wb_data
    );
endinterface

// File: rtl/core_regfile_wt.sv
// ---------------------------------------------------------------------------
// core_regfile_wt
// 2**REG_AW x DATA_W register file, two combinational read ports and one
// write port. A read of the register being written in the same cycle returns
// the write data (write-through), so the reader never sees a stale value.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears all regs)
//   ra_a, ra_b     : read addresses
//   rdata_a/b      : read data
//   we, wa, wd     : write enable, address, data
// ---------------------------------------------------------------------------
module core_regfile_wt #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_AW-1:0]        ra_a,
    input  logic [REG_AW-1:0]        ra_b,
    output logic signed [DATA_W-1:0] rdata_a,
    output logic signed [DATA_W-1:0] rdata_b,
    input  logic                     we,
    input  logic [REG_AW-1:0]        wa,
    input  logic signed [DATA_W-1:0] wd
);
    localparam int NREGS = 1 << REG_AW;

    logic signed [DATA_W-1:0] regs [0:NREGS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rdata_a = (we && (wa == ra_a)) ? wd : regs[ra_a];
    assign rdata_b = (we && (wa == ra_b)) ? wd : regs[ra_b];
endmodule

// File: rtl/pipelined_core_param.sv
// ---------------------------------------------------------------------------
// pipelined_core_param
// Four-stage in-order core (IF, ID, EX, WB) with configurable widths.
//   MOVI rd,imm : R[rd] = sext(imm)
//   ADD  rd,rs  : R[rd] = R[rd] + R[rs]
//   SUB  rd,rs  : R[rd] = R[rd] - R[rs]
//   JMP  imm    : PC = PC_of_jmp + sext(imm), resolved in ID, flushes the
//                 one younger fetched instruction
// Hazards: EX/WB -> EX forwarding covers distance 1, the write-through
// register file covers distance 2; no interlocks exist.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : pipelined_core_param_if.master (imem_* fetch port, wb_* retire port)
// ---------------------------------------------------------------------------
module pipelined_core_param
    import core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 3,
    parameter int PC_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_core_param_if.master  bus
);
    localparam int INSTR_W = instr_w(REG_AW, IMM_W);
    localparam int OP_LSB  = op_lsb(REG_AW, IMM_W);
    localparam int RD_LSB  = rd_lsb(IMM_W);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } if_id_t;

    typedef struct packed {
        opcode_e                  op;
        logic [REG_AW-1:0]        rd;
        logic [REG_AW-1:0]        rs;
        logic signed [DATA_W-1:0] opa;
        logic signed [DATA_W-1:0] opb;
        logic signed [DATA_W-1:0] immx;
    } id_ex_t;

    typedef struct packed {
        logic                     wr;
        logic [REG_AW-1:0]        rd;
        logic signed [DATA_W-1:0] res;
    } ex_wb_t;

    function automatic logic signed [DATA_W-1:0] sext_data(input logic [IMM_W-1:0] imm);
        return DATA_W'($signed(imm));
    endfunction

    function automatic logic [PC_W-1:0] sext_pc(input logic [IMM_W-1:0] imm);
        return PC_W'($signed(imm));
    endfunction

    // Results wrap modulo 2**DATA_W; JMP produces no result.
    function automatic logic signed [DATA_W-1:0] alu(
        input opcode_e                  op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] immx
    );
        case (op)
            OP_MOVI: return immx;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return '0;
        endcase
    endfunction

    logic [PC_W-1:0] pc;

    logic   vld_p0;
    if_id_t if_id_p0;
    logic   vld_p1;
    id_ex_t id_ex_p1;
    logic   vld_p2;
    ex_wb_t ex_wb_p2;

    opcode_e                  dec_op;
    logic [REG_AW-1:0]        dec_rd;
    logic [REG_AW-1:0]        dec_rs;
    logic [IMM_W-1:0]         dec_imm;
    logic                     jmp_taken;
    logic signed [DATA_W-1:0] rf_rdata_a;
    logic signed [DATA_W-1:0] rf_rdata_b;
    logic                     rf_we;
    logic                     fwd_en;
    logic signed [DATA_W-1:0] fwd_a;
    logic signed [DATA_W-1:0] fwd_b;
    logic signed [DATA_W-1:0] ex_res;

    // ---- IF -> IF/ID (p0) ----
    // A jump in ID wins over both the stall and the PC+1 update, and the
    // instruction fetched alongside it is dropped by loading a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            vld_p0 <= 1'b0;
        end else if (jmp_taken) begin
            pc     <= if_id_p0.pc + sext_pc(dec_imm);
            vld_p0 <= 1'b0;
        end else if (bus.imem_valid) begin
            pc     <= pc + PC_W'(1);
            vld_p0 <= 1'b1;
        end else begin
            vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.imem_valid && !jmp_taken) begin
            if_id_p0 <= '{instr: bus.imem_rdata, pc: pc};
        end
    end

    assign bus.imem_addr = pc;

    // ---- ID -> ID/EX (p1) ----
    assign dec_op    = opcode_e'(if_id_p0.instr[OP_LSB +: 2]);
    assign dec_rd    = if_id_p0.instr[RD_LSB +: REG_AW];
    assign dec_imm   = if_id_p0.instr[IMM_W-1:0];
    assign dec_rs    = dec_imm[REG_AW-1:0];
    assign jmp_taken = vld_p0 && (dec_op == OP_JMP);

    core_regfile_wt #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_a    (dec_rd),
        .ra_b    (dec_rs),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .wa      (ex_wb_p2.rd),
        .wd      (ex_wb_p2.res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            id_ex_p1 <= '{op:   dec_op,
                          rd:   dec_rd,
                          rs:   dec_rs,
                          opa:  rf_rdata_a,
                          opb:  rf_rdata_b,
                          immx: sext_data(dec_imm)};
        end
    end

    // ---- EX -> EX/WB (p2) ----
    // The instruction one ahead is still in EX/WB and has not reached the
    // register file yet, so its result overrides either stale operand.
    assign fwd_en = vld_p2 && ex_wb_p2.wr;
    assign fwd_a  = (fwd_en && (ex_wb_p2.rd == id_ex_p1.rd)) ? ex_wb_p2.res : id_ex_p1.opa;
    assign fwd_b  = (fwd_en && (ex_wb_p2.rd == id_ex_p1.rs)) ? ex_wb_p2.res : id_ex_p1.opb;
    assign ex_res = alu(id_ex_p1.op, fwd_a, fwd_b, id_ex_p1.immx);

    // EX/WB feeds the observe port directly, so it is cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            ex_wb_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                ex_wb_p2 <= '{wr: op_writes(id_ex_p1.op), rd: id_ex_p1.rd, res: ex_res};
            end
        end
    end

    // ---- WB ----
    assign rf_we        = vld_p2 && ex_wb_p2.wr;
    assign bus.wb_valid = rf_we;
    assign bus.wb_rd    = ex_wb_p2.rd;
    assign bus.wb_data  = ex_wb_p2.res;
endmodule

// File: tb/tb_pipelined_core_param.sv
// ---------------------------------------------------------------------------
// tb_pipelined_core_param
// Cycle-table checks of reset, forwarding, write-through, jump flush and
// fetch stall; hand sequences for mid-stream reset and a backward jump
// resolved during a stall with PC wrap; then a random program with random
// fetch stalls scored against an instruction-level model.
// ---------------------------------------------------------------------------
module tb_pipelined_core_param;
    localparam int DATA_W = 8;
    localparam int REG_AW = 3;
    localparam int IMM_W  = 3;
    localparam int PC_W   = 8;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] instr;
        logic [7:0] addr;
        logic       wv;
        logic       chk_rd;
        logic [2:0] rd;
        logic [7:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic use_mem = 1'b0;
    logic [7:0] tbl_instr = 8'h00;
    logic [7:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_core_param_if #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .IMM_W  (IMM_W),
        .PC_W   (PC_W)
    ) bus ();

    assign bus.imem_rdata = use_mem ? mem[bus.imem_addr] : tbl_instr;

    pipelined_core_param #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .IMM_W  (IMM_W),
        .PC_W   (PC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] ins,
                                input logic [7:0] a, input logic wv, input logic c,
                                input logic [2:0] rd, input logic [7:0] d);
        vec_t v;
        v.rst = r; v.iv = iv; v.instr = ins; v.addr = a;
        v.wv = wv; v.chk_rd = c; v.rd = rd; v.data = d;
        return v;
    endfunction

    // Outputs observed in a cycle are checked first, then that cycle's inputs are driven.
    task automatic step(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        check($sformatf("%s imem_addr", tag), 32'(bus.imem_addr), 32'(v.addr));
        check($sformatf("%s wb_valid", tag), 32'(bus.wb_valid), 32'(v.wv));
        if (v.chk_rd) begin
            check($sformatf("%s wb_rd", tag), 32'(bus.wb_rd), 32'(v.rd));
            check($sformatf("%s wb_data", tag), 32'(bus.wb_data), 32'(v.data));
        end
        rst            = v.rst;
        bus.imem_valid = v.iv;
        tbl_instr      = v.instr;
    endtask

    // Instruction-level reference: architectural PC and registers.
    int mpc;
    int mregs [0:7];

    function automatic int sx3(input int v);
        return (v >= 4) ? v - 8 : v;
    endfunction

    task automatic model_next(output int erd, output int edata, output bit ok);
        int ins, op, rd, imm;
        ok = 1'b0;
        erd = 0;
        edata = 0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            ins = int'(mem[mpc]);
            op  = ins / 64;
            rd  = (ins / 8) % 8;
            imm = ins % 8;
            if (op == 3) begin
                mpc = (mpc + sx3(imm) + 256) % 256;
            end else begin
                if (op == 0)      mregs[rd] = (sx3(imm) + 256) % 256;
                else if (op == 1) mregs[rd] = (mregs[rd] + mregs[imm]) % 256;
                else              mregs[rd] = (mregs[rd] - mregs[imm] + 256) % 256;
                mpc   = (mpc + 1) % 256;
                erd   = rd;
                edata = mregs[rd];
                ok    = 1'b1;
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        int erd, edata, n_ret;
        bit ok;

        bus.imem_valid = 1'b0;

        // reset held, then idle
        tbl.push_back(mk(1,0,8'h00, 8'h00,0,1,0,8'h00));
        tbl.push_back(mk(1,0,8'h00, 8'h00,0,1,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h00,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h00,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h00,0,1,0,8'h00));
        // distance-1 forwarding: MOVI R1,3 ; ADD R1,R1
        tbl.push_back(mk(0,1,8'h0B, 8'h00,0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h49, 8'h01,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h02,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h02,1,1,1,8'h03));
        tbl.push_back(mk(0,0,8'h00, 8'h02,1,1,1,8'h06));
        tbl.push_back(mk(0,0,8'h00, 8'h02,0,0,0,8'h00));
        tbl.push_back(mk(1,0,8'h00, 8'h02,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h00,0,1,0,8'h00));
        // sign extension + distance-2 write-through
        tbl.push_back(mk(0,1,8'h17, 8'h00,0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h0B, 8'h01,0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h92, 8'h02,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h03,1,1,2,8'hFF));
        tbl.push_back(mk(0,0,8'h00, 8'h03,1,1,1,8'h03));
        tbl.push_back(mk(0,0,8'h00, 8'h03,1,1,2,8'h00));
        tbl.push_back(mk(1,0,8'h00, 8'h03,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h00,0,0,0,8'h00));
        // jump flush: JMP +3 ; (flushed MOVI R1,3) ; MOVI R1,0 at 3
        tbl.push_back(mk(0,1,8'hC3, 8'h00,0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h0B, 8'h01,0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h08, 8'h03,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h04,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h04,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h04,1,1,1,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h04,0,0,0,8'h00));
        tbl.push_back(mk(1,0,8'h00, 8'h04,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h00,0,0,0,8'h00));
        // fetch stall of two cycles before SUB R2,R2
        tbl.push_back(mk(0,1,8'h17, 8'h00,0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h0B, 8'h01,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h02,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h02,1,1,2,8'hFF));
        tbl.push_back(mk(0,1,8'h92, 8'h02,1,1,1,8'h03));
        tbl.push_back(mk(0,0,8'h00, 8'h03,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h03,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h03,1,1,2,8'h00));
        tbl.push_back(mk(1,0,8'h00, 8'h03,0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00, 8'h00,0,0,0,8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // mid-stream reset right after ADD R1,R1 is fetched
        step(mk(0,1,8'h0B, 8'h00,0,0,0,8'h00), "mrst_c0");
        step(mk(0,1,8'h49, 8'h01,0,0,0,8'h00), "mrst_c1");
        step(mk(1,0,8'h00, 8'h02,0,0,0,8'h00), "mrst_c2");
        step(mk(0,0,8'h00, 8'h00,0,1,0,8'h00), "mrst_c3");
        step(mk(0,0,8'h00, 8'h00,0,0,0,8'h00), "mrst_c4");
        step(mk(0,1,8'h49, 8'h00,0,0,0,8'h00), "mrst_c5");
        step(mk(0,0,8'h00, 8'h01,0,0,0,8'h00), "mrst_c6");
        step(mk(0,0,8'h00, 8'h01,0,0,0,8'h00), "mrst_c7");
        step(mk(0,0,8'h00, 8'h01,1,1,1,8'h00), "mrst_c8");

        // backward JMP -2 resolved while fetch is stalled, then PC wraps FF -> 00
        step(mk(1,0,8'h00, 8'h01,0,0,0,8'h00), "bj_rst");
        step(mk(0,0,8'h00, 8'h00,0,0,0,8'h00), "bj_idle");
        step(mk(0,1,8'hC6, 8'h00,0,0,0,8'h00), "bj_c0");
        step(mk(0,0,8'h00, 8'h01,0,0,0,8'h00), "bj_c1");
        step(mk(0,1,8'h1A, 8'hFE,0,0,0,8'h00), "bj_c2");
        step(mk(0,0,8'h00, 8'hFF,0,0,0,8'h00), "bj_c3");
        step(mk(0,0,8'h00, 8'hFF,0,0,0,8'h00), "bj_c4");
        step(mk(0,1,8'h5B, 8'hFF,1,1,3,8'h02), "bj_c5");
        step(mk(0,0,8'h00, 8'h00,0,0,0,8'h00), "bj_c6");
        step(mk(0,0,8'h00, 8'h00,0,0,0,8'h00), "bj_c7");
        step(mk(0,0,8'h00, 8'h00,1,1,3,8'h04), "bj_c8");

        // random program with random fetch stalls, forward-only jumps
        for (int i = 0; i < 256; i++) begin
            int op, rd, imm;
            op  = int'($urandom_range(0, 3));
            rd  = int'($urandom_range(0, 7));
            imm = (op == 3) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 7));
            mem[i] = 8'(op * 64 + rd * 8 + imm);
        end
        mpc = 0;
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        n_ret = 0;

        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.imem_valid = 1'b0;
        use_mem = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (bus.wb_valid === 1'b1) begin
                model_next(erd, edata, ok);
                if (!ok) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand model: no writing instruction found for retire %0d", n_ret);
                end else begin
                    check($sformatf("rand retire%0d rd,data", n_ret),
                          {21'd0, bus.wb_rd, bus.wb_data}, 32'(erd * 256 + edata));
                end
                n_ret++;
            end
            bus.imem_valid = ($urandom_range(0, 3) != 0);
        end
        check("rand retire count >= 500", 32'(n_ret >= 500), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
